// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU issue controller: opcodes, command word layout,
// register-file geometry and small opcode-decode helpers.
package alu_pkg;

  localparam int DATA_W    = 4;
  localparam int OP_W      = 3;
  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

  // Command word layout, LSB first: imm, src_b, src_a, dst, op
  localparam int IMM_LSB   = 0;
  localparam int SRC_B_LSB = IMM_LSB + DATA_W;
  localparam int SRC_A_LSB = SRC_B_LSB + REG_IDX_W;
  localparam int DST_LSB   = SRC_A_LSB + REG_IDX_W;
  localparam int OP_LSB    = DST_LSB + REG_IDX_W;
  localparam int CMD_W     = OP_LSB + OP_W;

  localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_AND   = 3'b010;
  localparam logic [OP_W-1:0] OP_OR    = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
  localparam logic [OP_W-1:0] OP_LOADI = 3'b101;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [REG_IDX_W-1:0] dst;
    logic [REG_IDX_W-1:0] src_a;
    logic [REG_IDX_W-1:0] src_b;
    logic [DATA_W-1:0]    imm;
  } cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    logic res;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOADI: res = 1'b1;
      default:                                         res = 1'b0;
    endcase
    return res;
  endfunction

  // LOADI and illegal commands do not use the ALU; park it on ADD.
  function automatic logic [OP_W-1:0] alu_op_of(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] res;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: res = op;
      default:                               res = OP_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue controller: first-word-fall-through read, extra
// pointer bit distinguishes full from empty, no pass-through when full.
module alu_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty     = (wptr_r == rptr_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rptr_r[AW-1:0]];

  // Pointer update and storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r[AW-1:0]] <= wdata;
        wptr_r                <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller upstream of the combinational 4-bit ALU: buffers commands, reads a
// 4x4 register file, drives registered ALU operands and writes results back next cycle.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic [3:0] cmd_imm,
  input  logic       hold,
  output logic [2:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_v,
  output logic       busy,
  output logic       err_illegal,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_data
);

  import alu_pkg::*;

  cmd_t                 cmd_in_s;
  cmd_t                 head_s;
  logic [CMD_W-1:0]     head_bits_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 pop_s;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 wb_en_s;
  logic                 wb_write_s;
  logic [DATA_W-1:0]    wb_data_s;
  logic [DATA_W-1:0]    opnd_a_s;
  logic [DATA_W-1:0]    opnd_b_s;

  logic [OP_W-1:0]      exec_op_r;
  logic [REG_IDX_W-1:0] exec_dst_r;
  logic [DATA_W-1:0]    exec_imm_r;
  logic [DATA_W-1:0]    regs_r [NUM_REGS];
  logic [OP_W-1:0]      alu_opcode_r;
  logic [DATA_W-1:0]    alu_a_r;
  logic [DATA_W-1:0]    alu_b_r;
  logic                 flag_c_r;
  logic                 flag_z_r;
  logic                 flag_v_r;
  logic                 err_r;

  assign cmd_in_s    = {cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm};
  assign head_s      = head_bits_s;
  assign cmd_ready   = !fifo_full_s;
  assign push_s      = cmd_valid && !fifo_full_s;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (cmd_in_s),
    .rdata (head_bits_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, pop and writeback-enable decode
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    wb_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && !hold) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wb_en_s = 1'b1;
        if (!fifo_empty_s && !hold) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Writeback value and operand selection with forwarding from the in-flight command
  always_comb begin
    wb_write_s = wb_en_s && op_writes_reg(exec_op_r);
    wb_data_s  = (exec_op_r == OP_LOADI) ? exec_imm_r : alu_result;
    opnd_a_s   = (wb_write_s && (exec_dst_r == head_s.src_a)) ? wb_data_s : regs_r[head_s.src_a];
    opnd_b_s   = (wb_write_s && (exec_dst_r == head_s.src_b)) ? wb_data_s : regs_r[head_s.src_b];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Execute register and ALU operand registers, loaded on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_op_r    <= 3'b000;
      exec_dst_r   <= 2'b00;
      exec_imm_r   <= 4'b0000;
      alu_opcode_r <= 3'b000;
      alu_a_r      <= 4'b0000;
      alu_b_r      <= 4'b0000;
    end else if (pop_s) begin
      exec_op_r    <= head_s.op;
      exec_dst_r   <= head_s.dst;
      exec_imm_r   <= head_s.imm;
      alu_opcode_r <= alu_op_of(head_s.op);
      alu_a_r      <= opnd_a_s;
      alu_b_r      <= opnd_b_s;
    end
  end

  // Register file writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 4'b0000;
      end
    end else if (wb_write_s) begin
      regs_r[exec_dst_r] <= wb_data_s;
    end
  end

  // Flag and sticky illegal-opcode update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_v_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (wb_en_s) begin
      case (exec_op_r)
        OP_ADD, OP_SUB: begin
          flag_c_r <= alu_cout;
          flag_z_r <= alu_zero;
          flag_v_r <= alu_overflow;
        end
        OP_AND, OP_OR, OP_XOR: begin
          flag_c_r <= 1'b0;
          flag_z_r <= alu_zero;
          flag_v_r <= 1'b0;
        end
        OP_LOADI: begin
          flag_c_r <= flag_c_r;
        end
        default: begin
          err_r <= 1'b1;
        end
      endcase
    end
  end

  assign alu_opcode  = alu_opcode_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign flag_c      = flag_c_r;
  assign flag_z      = flag_z_r;
  assign flag_v      = flag_v_r;
  assign err_illegal = err_r;
  assign busy        = (state_r == ST_EXEC) || !fifo_empty_s;
  assign rd_data     = regs_r[rd_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 4-bit ALU on the side; expectations
// are queued by cycle number and checked by an independent monitor on the falling edge.
module tb_alu_issue_ctrl;

  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [1:0] cmd_dst = 2'b00;
  logic [1:0] cmd_src_a = 2'b00;
  logic [1:0] cmd_src_b = 2'b00;
  logic [3:0] cmd_imm = 4'b0000;
  logic       hold = 1'b0;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic       alu_zero;
  logic       alu_overflow;
  logic       flag_c;
  logic       flag_z;
  logic       flag_v;
  logic       busy;
  logic       err_illegal;
  logic [1:0] rd_sel = 2'b00;
  logic [3:0] rd_data;
  logic [4:0] alu_sum5;

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dst      (cmd_dst),
    .cmd_src_a    (cmd_src_a),
    .cmd_src_b    (cmd_src_b),
    .cmd_imm      (cmd_imm),
    .hold         (hold),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .busy         (busy),
    .err_illegal  (err_illegal),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data)
  );

  always #10 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural alu_4bit: SUB carry is a + ~b + 1
  always_comb begin
    alu_sum5     = 5'b00000;
    alu_result   = 4'b0000;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_sum5     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_sum5[3:0];
        alu_cout     = alu_sum5[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum5[3] != alu_a[3]);
      end
      3'b001: begin
        alu_sum5     = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'b00001;
        alu_result   = alu_sum5[3:0];
        alu_cout     = alu_sum5[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_sum5[3] != alu_a[3]);
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = 4'b0000;
    endcase
    alu_zero = (alu_result == 4'b0000);
  end

  typedef enum int {K_REG, K_FLAGS, K_Z, K_READY, K_BUSY} kind_t;
  typedef struct {
    int         cyc;
    kind_t      kind;
    logic [1:0] idx;
    logic [3:0] want;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Insert keeping the queue ordered by check cycle. FLAGS want = {err, c, z, v}.
  function automatic void sb_expect(input int cyc, input kind_t kind, input logic [1:0] idx,
                                    input logic [3:0] want, input string name);
    exp_t e;
    int   pos;
    e.cyc  = cyc;
    e.kind = kind;
    e.idx  = idx;
    e.want = want;
    e.name = name;
    pos = sb_q.size();
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc > cyc) begin
        pos = i;
        break;
      end
    end
    sb_q.insert(pos, e);
  endfunction

  initial begin : monitor
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
        e = sb_q.pop_front();
        rd_sel = e.idx;
        #1;
        case (e.kind)
          K_REG:   act = rd_data;
          K_FLAGS: act = {err_illegal, flag_c, flag_z, flag_v};
          K_Z:     act = {3'b000, flag_z};
          K_READY: act = {3'b000, cmd_ready};
          K_BUSY:  act = {3'b000, busy};
          default: act = 4'bxxxx;
        endcase
        n_vec++;
        if (e.cyc != cyc_cnt || act !== e.want) begin
          n_fail++;
          $display("FAIL %s at cycle %0d (due %0d): got %b, expected %b",
                   e.name, cyc_cnt, e.cyc, act, e.want);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [3:0] imm, output int pe);
    int waited;
    waited    = 0;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src_a = sa;
    cmd_src_b = sb;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_handshake: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, waited);
    end
    pe = cyc_cnt + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int c;
    int p0;
    int p1;
    int p2;
    int t;
    int drain;

    // Reset state
    idle(2);
    c = cyc_cnt;
    sb_expect(c + 1, K_READY, 2'd0, 4'b0001, "rst_ready");
    sb_expect(c + 1, K_BUSY,  2'd0, 4'b0000, "rst_busy");
    idle(1);
    rst_n = 1'b1;
    c = cyc_cnt;
    sb_expect(c + 1, K_REG,   2'd0, 4'b0000, "rst_r0");
    sb_expect(c + 1, K_REG,   2'd3, 4'b0000, "rst_r3");
    sb_expect(c + 1, K_FLAGS, 2'd0, 4'b0000, "rst_flags");
    idle(2);

    // Basic ADD with the FIFO initially empty
    issue(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'b1010, p0);
    sb_expect(p0 + 2, K_REG, 2'd0, 4'b1010, "t1_r0");
    issue(OP_LOADI, 2'd1, 2'd0, 2'd0, 4'b0101, p1);
    sb_expect(p1 + 2, K_REG, 2'd1, 4'b0101, "t1_r1");
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 4'b0000, p2);
    sb_expect(p2 + 1, K_REG,   2'd2, 4'b0000, "t1_r2_early");
    sb_expect(p2 + 1, K_BUSY,  2'd0, 4'b0001, "t1_busy");
    sb_expect(p2 + 2, K_REG,   2'd2, 4'b1111, "t1_r2");
    sb_expect(p2 + 2, K_FLAGS, 2'd0, 4'b0000, "t1_flags");
    sb_expect(p2 + 2, K_BUSY,  2'd0, 4'b0000, "t1_idle");
    idle(3);

    // Dependent back-to-back via forwarding
    issue(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'b1111, p0);
    sb_expect(p0 + 2, K_REG, 2'd0, 4'b1111, "t2_r0");
    issue(OP_ADD, 2'd1, 2'd0, 2'd0, 4'b0000, p1);
    sb_expect(p1 + 2, K_REG,   2'd1, 4'b1110, "t2_r1");
    sb_expect(p1 + 2, K_FLAGS, 2'd0, 4'b0100, "t2_flags");
    idle(3);

    // SUB to zero, then XOR that depends on it
    issue(OP_LOADI, 2'd3, 2'd0, 2'd0, 4'b0110, p0);
    sb_expect(p0 + 2, K_REG, 2'd3, 4'b0110, "t3_r3_pre");
    issue(OP_SUB, 2'd3, 2'd0, 2'd0, 4'b0000, p1);
    sb_expect(p1 + 2, K_REG, 2'd3, 4'b0000, "t3_sub_r3");
    sb_expect(p1 + 2, K_Z,   2'd0, 4'b0001, "t3_sub_z");
    issue(OP_XOR, 2'd3, 2'd0, 2'd3, 4'b0000, p2);
    sb_expect(p2 + 2, K_REG,   2'd3, 4'b1111, "t3_xor_r3");
    sb_expect(p2 + 2, K_FLAGS, 2'd0, 4'b0000, "t3_xor_flags");
    idle(3);

    // Backpressure: fill under hold, fifth command waits, then all drain in order
    hold = 1'b1;
    issue(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'b0011, p0);
    issue(OP_LOADI, 2'd1, 2'd0, 2'd0, 4'b0100, p0);
    issue(OP_ADD,   2'd2, 2'd0, 2'd1, 4'b0000, p0);
    issue(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'b1000, p0);
    t = cyc_cnt;
    cmd_op    = OP_ADD;
    cmd_dst   = 2'd3;
    cmd_src_a = 2'd0;
    cmd_src_b = 2'd1;
    cmd_imm   = 4'b0000;
    cmd_valid = 1'b1;
    sb_expect(t + 1, K_READY, 2'd0, 4'b0000, "t4_full1");
    sb_expect(t + 1, K_BUSY,  2'd0, 4'b0001, "t4_busy");
    sb_expect(t + 2, K_READY, 2'd0, 4'b0000, "t4_full2");
    sb_expect(t + 2, K_REG,   2'd0, 4'b1111, "t4_held_r0");
    idle(2);
    hold = 1'b0;
    sb_expect(t + 3, K_READY, 2'd0, 4'b0001, "t4_ready");
    sb_expect(t + 4, K_REG,   2'd0, 4'b0011, "t4_q1");
    sb_expect(t + 5, K_REG,   2'd1, 4'b0100, "t4_q2");
    sb_expect(t + 6, K_REG,   2'd2, 4'b0111, "t4_q3");
    sb_expect(t + 6, K_FLAGS, 2'd0, 4'b0000, "t4_q3_flags");
    sb_expect(t + 7, K_REG,   2'd0, 4'b1000, "t4_q4");
    sb_expect(t + 8, K_REG,   2'd3, 4'b1100, "t4_q5");
    sb_expect(t + 8, K_FLAGS, 2'd0, 4'b0000, "t4_q5_flags");
    issue(OP_ADD, 2'd3, 2'd0, 2'd1, 4'b0000, p0);
    idle(6);

    // Illegal opcode between two ADDs
    issue(OP_ADD, 2'd3, 2'd0, 2'd0, 4'b0000, p0);
    sb_expect(p0 + 2, K_REG,   2'd3, 4'b0000, "t5_pre_r3");
    sb_expect(p0 + 2, K_FLAGS, 2'd0, 4'b0111, "t5_pre_flags");
    issue(3'b110, 2'd2, 2'd0, 2'd0, 4'b1001, p1);
    sb_expect(p1 + 2, K_REG,   2'd2, 4'b0111, "t5_ill_r2");
    sb_expect(p1 + 2, K_FLAGS, 2'd0, 4'b1111, "t5_ill_flags");
    issue(OP_ADD, 2'd1, 2'd0, 2'd2, 4'b0000, p2);
    sb_expect(p2 + 2, K_REG,   2'd1, 4'b1111, "t5_add_r1");
    sb_expect(p2 + 2, K_FLAGS, 2'd0, 4'b1000, "t5_add_flags");
    sb_expect(p2 + 4, K_FLAGS, 2'd0, 4'b1000, "t5_sticky");
    idle(5);

    // Reset during EXEC of ADD r2 with two commands queued
    hold = 1'b1;
    issue(OP_ADD,   2'd2, 2'd1, 2'd1, 4'b0000, p0);
    issue(OP_LOADI, 2'd0, 2'd0, 2'd0, 4'b0101, p1);
    issue(OP_LOADI, 2'd3, 2'd0, 2'd0, 4'b0110, p1);
    hold = 1'b0;
    sb_expect(p0 + 3, K_REG,  2'd2, 4'b0111, "t6_pre_r2");
    sb_expect(p0 + 3, K_BUSY, 2'd0, 4'b0001, "t6_pre_busy");
    sb_expect(p0 + 4, K_READY, 2'd0, 4'b0001, "t6_rst_ready");
    sb_expect(p0 + 4, K_BUSY,  2'd0, 4'b0000, "t6_rst_busy");
    sb_expect(p0 + 6, K_REG,   2'd0, 4'b0000, "t6_r0");
    sb_expect(p0 + 6, K_REG,   2'd1, 4'b0000, "t6_r1");
    sb_expect(p0 + 6, K_REG,   2'd2, 4'b0000, "t6_r2");
    sb_expect(p0 + 6, K_REG,   2'd3, 4'b0000, "t6_r3");
    sb_expect(p0 + 6, K_FLAGS, 2'd0, 4'b0000, "t6_flags");
    sb_expect(p0 + 6, K_BUSY,  2'd0, 4'b0000, "t6_busy");
    sb_expect(p0 + 7, K_REG,   2'd2, 4'b0000, "t6_r2_late");
    sb_expect(p0 + 7, K_READY, 2'd0, 4'b0001, "t6_ready");
    idle(1);
    #5 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Recovery after reset
    issue(OP_LOADI, 2'd1, 2'd0, 2'd0, 4'b0001, p0);
    issue(OP_ADD,   2'd0, 2'd1, 2'd1, 4'b0000, p1);
    sb_expect(p1 + 2, K_REG,   2'd0, 4'b0010, "t7_r0");
    sb_expect(p1 + 2, K_FLAGS, 2'd0, 4'b0000, "t7_flags");

    drain = 0;
    while (sb_q.size() > 0 && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    if (sb_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d checks left unchecked, expected 0", sb_q.size());
    end
    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-driven issue controller that sits directly upstream of the 4-bit ALU (`alu_4bit`). It accepts register-addressed commands over a valid/ready handshake and buffers them in a small FIFO. It reads operands from an internal 4-entry × 4-bit register file, drives registered `opcode`/`a`/`b` into the combinational ALU, and writes the result and flags back one cycle later. A result-forwarding path sustains one command per cycle, including back-to-back dependent operations.

## Interface
- `DEPTH`, 4, command FIFO depth (power of two, ≥2)
- `clk` input 1 rising-edge clock
- `rst_n` input 1 asynchronous, active-low reset
- `cmd_valid` input 1 command offered
- `cmd_ready` output 1 FIFO can accept; equals !full
- `cmd_op` input 3 opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LOADI, 110/111 illegal
- `cmd_dst` input 2 destination register index
- `cmd_src_a` input 2 operand A register index
- `cmd_src_b` input 2 operand B register index
- `cmd_imm` input 4 immediate for LOADI
- `hold` input 1 inhibits FIFO pops; the in-flight command still completes
- `alu_opcode` output 3 registered opcode to ALU
- `alu_a` output 4 registered operand A to ALU
- `alu_b` output 4 registered operand B to ALU
- `alu_result` input 4 ALU result
- `alu_cout` input 1 ALU carry-out
- `alu_zero` input 1 ALU zero flag
- `alu_overflow` input 1 ALU signed overflow
- `flag_c` output 1 latched carry flag
- `flag_z` output 1 latched zero flag
- `flag_v` output 1 latched overflow flag
- `busy` output 1 high in EXEC or when FIFO non-empty
- `err_illegal` output 1 sticky illegal-opcode flag
- `rd_sel` input 2 debug read index
- `rd_data` output 4 combinational `regs[rd_sel]`

## Operation
- **Handshake:**
  - A push occurs on an edge where `cmd_valid && cmd_ready`.
  - The command is `{op,dst,src_a,src_b,imm}`.
  - Command fields must be stable while `cmd_valid` is high.
  - There is no pass-through when full: a simultaneous pop does not raise `cmd_ready` in the same cycle.
- **FSM states:** IDLE and EXEC.
  - IDLE, FIFO non-empty and `!hold`: pop, load the execute register, go to EXEC.
  - IDLE, otherwise: stay in IDLE.
  - EXEC: perform writeback. Then, if FIFO non-empty and `!hold`, pop the next command and stay in EXEC; otherwise go to IDLE.
- **Pop (operand load):**
  - `alu_a <= regs[src_a]` and `alu_b <= regs[src_b]`.
  - Forwarding: if the machine is in EXEC and the in-flight command writes a register, a source equal to the in-flight `dst` takes the value being written (ALU result or immediate).
  - `alu_opcode <= op`. For LOADI and illegal ops, `alu_opcode <= 000`; this value is don't-care for writeback.
- **Writeback (every EXEC cycle, using the in-flight command):**
  - ADD/SUB: `regs[dst] <= alu_result`; `flag_c <= alu_cout`, `flag_z <= alu_zero`, `flag_v <= alu_overflow`.
  - AND/OR/XOR: `regs[dst] <= alu_result`; `flag_z <= alu_zero`; `flag_c` and `flag_v` forced to 0.
  - LOADI: `regs[dst] <= imm`; flags unchanged.
  - Illegal: no register write; flags unchanged; `err_illegal <= 1`. The flag stays set until reset.
- **Arithmetic:** all data is 4-bit unsigned storage. The controller does no arithmetic itself; SUB means `a - b` as computed by the ALU.
- **Reset** (asynchronous and may assert mid-operation):
  - FIFO emptied; state IDLE; in-flight command discarded with no writeback.
  - All regs 0; `alu_opcode`/`alu_a`/`alu_b` 0; flags 0; `err_illegal` 0.
  - Resulting outputs: `cmd_ready` 1, `busy` 0, `rd_data` 0.

## Timing
- **Single command, empty FIFO, IDLE:**
  - Pushed at edge N.
  - Popped at edge N+1; `alu_*` are valid after N+1.
  - Written back at edge N+2; visible on `rd_data` and flags after N+2.
- **Throughput:** one command per cycle once in EXEC. A dependent command issued on the next cycle sees the new value via forwarding, with no bubble.
- **`hold`:** sampled only at pop decisions. Asserting it during EXEC lets the current command write back, then the FSM returns to IDLE.
- **Full FIFO:** `cmd_ready` = 0; the offered command is not accepted and the source must keep it asserted.
- FIFO pointers wrap modulo DEPTH; occupancy is tracked with a count or an extra pointer bit so full and empty are distinguishable.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants (OP_ADD…OP_LOADI)
  - command field widths/offsets and the command word width (13 bits)
  - register index width
- **Sub-module `alu_cmd_fifo`:**
  - parameterised width and DEPTH
  - synchronous push/pop, `full`/`empty`, asynchronous active-low reset
- The controller instantiates the FIFO and does not instantiate the ALU; both sit side by side under the datapath top.

## Test plan
1. **Basic ADD:** LOADI r0=1010, LOADI r1=0101, ADD r2=r0+r1 (ALU connected) -> r2=1111, Z=0, C=0, V=0; r2 readable 2 cycles after its push when the FIFO was empty.
2. **Dependent back-to-back:** LOADI r0=1111, then ADD r1=r0+r0 on consecutive cycles -> forwarding gives r1=1110, C=1, V=0; no stall cycles.
3. **SUB zero, then logic op:** with r0=1111, SUB r3=r0-r0 -> r3=0000, Z=1. Then XOR r3=r0^r3 -> r3=1111, Z=0, C=0, V=0.
4. **Backpressure:** hold=1, offer 5 commands -> 4 accepted, `cmd_ready`=0 on the 5th. Release hold -> all execute in push order, one per cycle, and the 5th is then accepted.
5. **Illegal opcode:** op=110 with dst=r2 -> r2 and flags unchanged, `err_illegal`=1 and sticky. A following ADD executes normally.
6. **Reset mid-operation:** assert `rst_n`=0 during EXEC of ADD r2 with 2 commands queued -> all regs 0, FIFO empty, `cmd_ready`=1, `busy`=0, no writeback of the aborted command.
